// File: rtl/ra_irq_demux_pkg.sv
// Shared types and constants for the RA[1:0] IRQ side-channel receiver.
// FSM encoding, counter widths and saturating-increment helpers.
package ra_irq_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEEK = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int              ERR_W    = 8;
    localparam logic [ERR_W-1:0] ERR_SAT = '1;
    localparam logic [3:0]      CNT4_SAT = 4'hF;
    localparam logic [2:0]      RUN3_SAT = 3'h7;

    function automatic logic [3:0] inc_sat4(input logic [3:0] v);
        return (v == CNT4_SAT) ? v : v + 4'd1;
    endfunction

    function automatic logic [2:0] inc_sat3(input logic [2:0] v);
        return (v == RUN3_SAT) ? v : v + 3'd1;
    endfunction

    function automatic logic [ERR_W-1:0] inc_sat8(input logic [ERR_W-1:0] v);
        return (v == ERR_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ra_irq_demux_sync2.sv
// Two-flop synchronizer with async clear; both stages are exposed so
// the caller can build edge detectors or compare successive samples.
module ra_irq_demux_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q1,
    output logic [W-1:0] q2
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q1 = s1_q;
    assign q2 = s2_q;

endmodule

// File: rtl/ra_irq_demux.sv
// Board-side receiver for the card's IRQ bit carried on RA[1:0] after PHI1
// rises: recovers, filters and qualifies the bit, and drives nIRQ pull-down.
module ra_irq_demux
    import ra_irq_demux_pkg::*;
#(
    parameter int WIN_LO   = 2,
    parameter int WIN_HI   = 6,
    parameter int FILT     = 2,
    parameter int MISS_MAX = 4
) (
    input  logic             C7M,
    input  logic             nRES,
    input  logic             PHI1,
    input  logic [1:0]       RA,
    input  logic             IRQEN,
    input  logic             ErrClr,
    output logic             nIRQ_OE,
    output logic             IRQ,
    output logic             Synced,
    output logic             FrameStb,
    output logic [ERR_W-1:0] ErrCnt
);

    localparam logic [3:0] WLO_V  = 4'(WIN_LO);
    localparam logic [3:0] WHI_V  = 4'(WIN_HI);
    localparam logic [2:0] FILT_V = 3'(FILT);
    localparam logic [3:0] MISS_V = 4'(MISS_MAX);

    logic       p1, p2;
    logic [1:0] raq, raqq;

    ra_irq_demux_sync2 #(.W(1)) u_phi_sync (
        .clk   (C7M),
        .rst_n (nRES),
        .d     (PHI1),
        .q1    (p1),
        .q2    (p2)
    );

    ra_irq_demux_sync2 #(.W(2)) u_ra_sync (
        .clk   (C7M),
        .rst_n (nRES),
        .d     (RA),
        .q1    (raq),
        .q2    (raqq)
    );

    state_e           state_q, state_d;
    logic [3:0]       w_q, w_d;
    logic [3:0]       miss_run_q, miss_run_d;
    logic [2:0]       same_run_q, same_run_d;
    logic             last_bit_q, last_bit_d;
    logic             irq_q, irq_d;
    logic             synced_q, synced_d;
    logic             frame_stb_q, frame_stb_d;
    logic             oe_q, oe_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic rise, pat, in_win, frame, malformed, rx_bit;
    logic hit, miss;

    assign rise      = p1 && !p2;
    assign pat       = !raqq[1] && raq[1];
    assign in_win    = (w_q >= WLO_V) && (w_q <= WHI_V);
    assign frame     = pat && (raqq[0] == raq[0]) && in_win;
    assign malformed = pat && (raqq[0] != raq[0]) && in_win;
    assign rx_bit    = raq[0];

    // A Rise always restarts the window; a Rise that lands in SEEK means
    // the previous window never produced a frame.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        hit     = 1'b0;
        miss    = 1'b0;
        if (rise) begin
            w_d     = 4'd0;
            state_d = ST_SEEK;
            miss    = (state_q == ST_SEEK);
        end else begin
            case (state_q)
                ST_SEEK: begin
                    w_d = inc_sat4(w_q);
                    if (frame) begin
                        hit     = 1'b1;
                        state_d = ST_HOLD;
                    end else if (malformed || (w_q == WHI_V)) begin
                        miss    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_HOLD: state_d = ST_HOLD;
                ST_IDLE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        miss_run_d  = miss_run_q;
        same_run_d  = same_run_q;
        last_bit_d  = last_bit_q;
        irq_d       = irq_q;
        synced_d    = synced_q;
        frame_stb_d = hit;
        err_cnt_d   = err_cnt_q;
        oe_d        = irq_q && IRQEN;
        if (miss) begin
            miss_run_d = inc_sat4(miss_run_q);
            err_cnt_d  = inc_sat8(err_cnt_q);
            if (miss_run_d >= MISS_V) begin
                synced_d   = 1'b0;
                irq_d      = 1'b0;
                same_run_d = 3'd0;
            end
        end
        if (hit) begin
            miss_run_d = 4'd0;
            synced_d   = 1'b1;
            same_run_d = (rx_bit == last_bit_q) ? inc_sat3(same_run_q) : 3'd1;
            last_bit_d = rx_bit;
            // Old sync flag: the frame that acquires sync cannot move IRQ.
            if (synced_q && (same_run_d >= FILT_V)) begin
                irq_d = rx_bit;
            end
        end
        if (ErrClr) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            state_q     <= ST_IDLE;
            w_q         <= 4'd0;
            miss_run_q  <= 4'd0;
            same_run_q  <= 3'd0;
            last_bit_q  <= 1'b0;
            irq_q       <= 1'b0;
            synced_q    <= 1'b0;
            frame_stb_q <= 1'b0;
            oe_q        <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            miss_run_q  <= miss_run_d;
            same_run_q  <= same_run_d;
            last_bit_q  <= last_bit_d;
            irq_q       <= irq_d;
            synced_q    <= synced_d;
            frame_stb_q <= frame_stb_d;
            oe_q        <= oe_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign nIRQ_OE  = oe_q;
    assign IRQ      = irq_q;
    assign Synced   = synced_q;
    assign FrameStb = frame_stb_q;
    assign ErrCnt   = err_cnt_q;

endmodule

// File: tb/tb_ra_irq_demux.sv
// Directed bench for ra_irq_demux: PHI1 periods of 7 high / 7 low C7M
// cycles with optional IRQ slots, checked with immediate assertions.
`timescale 1ns/1ps
module tb_ra_irq_demux;
    import ra_irq_demux_pkg::*;

    logic       C7M = 1'b0;
    logic       nRES;
    logic       PHI1;
    logic [1:0] RA;
    logic       IRQEN;
    logic       ErrClr;
    logic       nIRQ_OE;
    logic       IRQ;
    logic       Synced;
    logic       FrameStb;
    logic [7:0] ErrCnt;

    int tests = 0;
    int fails = 0;

    int     stb_cnt;
    logic   stb6, irq6, oe6, oe7;
    logic [7:0] err4;
    state_e st4;

    ra_irq_demux dut (
        .C7M      (C7M),
        .nRES     (nRES),
        .PHI1     (PHI1),
        .RA       (RA),
        .IRQEN    (IRQEN),
        .ErrClr   (ErrClr),
        .nIRQ_OE  (nIRQ_OE),
        .IRQ      (IRQ),
        .Synced   (Synced),
        .FrameStb (FrameStb),
        .ErrCnt   (ErrCnt)
    );

    always #5 C7M = ~C7M;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish (obs=timeout exp=finish)");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge C7M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One PHI1 period. w<0: no slots; else slot 1 driven in cycle w and
    // slot 2 in cycle w+1, so slot 2 sits in RAq while the window count is w.
    task automatic run_period(input int w, input logic b1, input logic b2,
                              input int clr_at, input bit glitch);
        stb_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            if (c > 0 && FrameStb === 1'b1) stb_cnt++;
            if (c == 4) begin
                err4 = ErrCnt;
                st4  = state_e'(dut.state_q);
            end
            if (c == 6) begin
                stb6 = FrameStb;
                irq6 = IRQ;
                oe6  = nIRQ_OE;
            end
            if (c == 7) oe7 = nIRQ_OE;
            PHI1 = (c < 7);
            if (glitch && c == 1) PHI1 = 1'b0;
            RA = 2'b00;
            if (w >= 0 && c == w)     RA = {1'b0, b1};
            if (w >= 0 && c == w + 1) RA = {1'b1, b2};
            ErrClr = (c == clr_at);
            tick();
        end
    endtask

    task automatic frame_bit(input logic b);
        run_period(3, b, b, -1, 1'b0);
    endtask

    initial begin
        nRES   = 1'b0;
        PHI1   = 1'b0;
        RA     = 2'b00;
        IRQEN  = 1'b1;
        ErrClr = 1'b0;
        tick();
        tick();
        chk("rst_irq", {7'd0, IRQ}, 8'd0);
        chk("rst_oe", {7'd0, nIRQ_OE}, 8'd0);
        chk("rst_synced", {7'd0, Synced}, 8'd0);
        chk("rst_stb", {7'd0, FrameStb}, 8'd0);
        chk("rst_err", ErrCnt, 8'd0);
        #2 nRES = 1'b1;
        tick();

        // acquire sync, then IRQ on the second matching frame
        frame_bit(1'b1);
        chk("t1_f1_synced", {7'd0, Synced}, 8'd1);
        chk("t1_f1_irq", {7'd0, IRQ}, 8'd0);
        chk("t1_f1_stb", 8'(stb_cnt), 8'd1);
        frame_bit(1'b1);
        chk("t1_f2_stb6", {7'd0, stb6}, 8'd1);
        chk("t1_f2_irq6", {7'd0, irq6}, 8'd1);
        chk("t1_f2_oe6", {7'd0, oe6}, 8'd0);
        chk("t1_f2_oe7", {7'd0, oe7}, 8'd1);
        frame_bit(1'b1);
        chk("t1_f3_irq", {7'd0, IRQ}, 8'd1);
        chk("t1_f3_oe", {7'd0, nIRQ_OE}, 8'd1);
        chk("t1_f3_stb", 8'(stb_cnt), 8'd1);
        chk("t1_err", ErrCnt, 8'd0);

        IRQEN = 1'b0;
        tick();
        tick();
        chk("irqen_off_oe", {7'd0, nIRQ_OE}, 8'd0);
        IRQEN = 1'b1;
        tick();
        tick();
        chk("irqen_on_oe", {7'd0, nIRQ_OE}, 8'd1);

        // isolated opposite bits are filtered out
        frame_bit(1'b1);
        chk("t2_a1", {7'd0, IRQ}, 8'd1);
        frame_bit(1'b0);
        chk("t2_a0", {7'd0, IRQ}, 8'd1);
        frame_bit(1'b1);
        chk("t2_b1", {7'd0, IRQ}, 8'd1);
        frame_bit(1'b0);
        chk("t2_c0", {7'd0, IRQ}, 8'd1);
        frame_bit(1'b0);
        chk("t2_d0", {7'd0, IRQ}, 8'd0);
        frame_bit(1'b1);
        chk("t2_e1", {7'd0, IRQ}, 8'd0);
        frame_bit(1'b1);
        chk("t2_f1", {7'd0, IRQ}, 8'd1);

        // four silent periods drop sync
        for (int i = 0; i < 3; i++) run_period(-1, 1'b0, 1'b0, -1, 1'b0);
        chk("t3_m3_synced", {7'd0, Synced}, 8'd1);
        chk("t3_m3_irq", {7'd0, IRQ}, 8'd1);
        chk("t3_m3_err", ErrCnt, 8'd3);
        run_period(-1, 1'b0, 1'b0, -1, 1'b0);
        chk("t3_m4_synced", {7'd0, Synced}, 8'd0);
        chk("t3_m4_irq", {7'd0, IRQ}, 8'd0);
        chk("t3_m4_err", ErrCnt, 8'd4);

        // resync, then a malformed frame
        frame_bit(1'b1);
        chk("t4_sync_irq", {7'd0, IRQ}, 8'd0);
        frame_bit(1'b1);
        chk("t4_sync_irq2", {7'd0, IRQ}, 8'd1);
        run_period(4, 1'b0, 1'b1, -1, 1'b0);
        chk("t4_mal_err", ErrCnt, 8'd5);
        chk("t4_mal_irq", {7'd0, IRQ}, 8'd1);
        chk("t4_mal_stb", 8'(stb_cnt), 8'd0);
        chk("t4_mal_state", {6'd0, dut.state_q}, {6'd0, ST_IDLE});

        // pattern outside the window, then a Rise at W=1
        run_period(9, 1'b1, 1'b1, -1, 1'b0);
        chk("t5_late_stb", 8'(stb_cnt), 8'd0);
        chk("t5_late_err", ErrCnt, 8'd6);
        run_period(-1, 1'b0, 1'b0, -1, 1'b1);
        chk("t5_glitch_err4", err4, 8'd7);
        chk("t5_glitch_st4", {6'd0, st4}, {6'd0, ST_SEEK});
        chk("t5_glitch_err", ErrCnt, 8'd8);
        chk("t5_synced", {7'd0, Synced}, 8'd0);

        // saturation and clear-wins
        for (int i = 0; i < 252; i++) run_period(-1, 1'b0, 1'b0, -1, 1'b0);
        chk("t6_sat", ErrCnt, 8'hFF);
        run_period(-1, 1'b0, 1'b0, 8, 1'b0);
        chk("t6_clr", ErrCnt, 8'd0);

        // async reset in the middle of SEEK
        run_period(-1, 1'b0, 1'b0, -1, 1'b0);
        frame_bit(1'b1);
        frame_bit(1'b1);
        frame_bit(1'b1);
        chk("t6_pre_irq", {7'd0, IRQ}, 8'd1);
        chk("t6_pre_oe", {7'd0, nIRQ_OE}, 8'd1);
        chk("t6_pre_err", ErrCnt, 8'd1);
        PHI1 = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_pre_state", {6'd0, dut.state_q}, {6'd0, ST_SEEK});
        #2 nRES = 1'b0;
        #1;
        chk("t6_rst_irq", {7'd0, IRQ}, 8'd0);
        chk("t6_rst_oe", {7'd0, nIRQ_OE}, 8'd0);
        chk("t6_rst_synced", {7'd0, Synced}, 8'd0);
        chk("t6_rst_stb", {7'd0, FrameStb}, 8'd0);
        chk("t6_rst_err", ErrCnt, 8'd0);
        chk("t6_rst_state", {6'd0, dut.state_q}, {6'd0, ST_IDLE});
        PHI1 = 1'b0;
        tick();
        nRES = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
